// File: rtl/gcbp_pkg.sv
// Shared definitions for the GCBP 4x4 subimage BRAM array: sizes, read-sequencer
// FSM encoding, stream tag layout and the BRAM one-hot decode.
package gcbp_pkg;

    localparam int GCBP_NUM_BRAMS  = 16;
    localparam int GCBP_SUBIMG_DIM = 4;
    localparam int GCBP_IDX_W      = $clog2(GCBP_NUM_BRAMS);
    localparam int GCBP_TAG_W      = $clog2(GCBP_SUBIMG_DIM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } gcbp_rd_state_e;

    typedef struct packed {
        logic [GCBP_TAG_W-1:0] vert;
        logic [GCBP_TAG_W-1:0] hori;
        logic                  sub_last;
        logic                  last;
    } gcbp_rd_tag_t;

    function automatic logic [GCBP_NUM_BRAMS-1:0] gcbp_onehot(input logic [GCBP_IDX_W-1:0] idx);
        logic [GCBP_NUM_BRAMS-1:0] r_vec;
        r_vec      = '0;
        r_vec[idx] = 1'b1;
        return r_vec;
    endfunction

endpackage

// File: rtl/gcbp_skid_fifo2.sv
// Two-entry FIFO used as the skid buffer behind the BRAM read port; a push and a
// pop in the same cycle are accepted even when full.
module gcbp_skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // NOTE: the two storage words are reset too, so the head reads 0 out of reset.
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/gcbp_bram_read_sequencer.sv
// Streams all 16 subimage BRAMs (index order, then word order) onto a tagged
// valid/ready stream. Optional o_stall_cnt is enabled by GCBP_RD_STALL_CNT_EN.
module gcbp_bram_read_sequencer
    import gcbp_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 9,
    parameter int WORDS_PER_BRAM = 512
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [GCBP_NUM_BRAMS-1:0]        o_bram_array_enb,
    output logic [ADDR_W-1:0]                o_bram_addrb,
    input  logic [GCBP_NUM_BRAMS*DATA_W-1:0] i_bram_array_doutb,
    output logic [DATA_W-1:0]                o_data,
    output logic [1:0]                       o_vert_subimage_cnt,
    output logic [1:0]                       o_hori_subimage_cnt,
    output logic                             o_sub_last,
    output logic                             o_last,
    output logic                             o_valid,
`ifdef GCBP_RD_STALL_CNT_EN
    output logic [15:0]                      o_stall_cnt,
`endif
    input  logic                             i_ready
);

    localparam int                    TAG_W       = $bits(gcbp_rd_tag_t);
    localparam int                    FIFO_W      = DATA_W + TAG_W;
    localparam logic [ADDR_W-1:0]     LP_ADDR_LAST = ADDR_W'(WORDS_PER_BRAM - 1);
    localparam logic [GCBP_IDX_W-1:0] LP_IDX_LAST  = GCBP_IDX_W'(GCBP_NUM_BRAMS - 1);

    gcbp_rd_state_e          r_state;
    gcbp_rd_state_e          w_next_state;
    logic [GCBP_IDX_W-1:0]   r_idx;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_inflight;
    logic [GCBP_IDX_W-1:0]   r_idx_d;
    gcbp_rd_tag_t            r_cap_tag;

    logic                    w_issue;
    logic                    w_start_acc;
    logic                    w_addr_last;
    logic                    w_idx_last;
    logic                    w_has_credit;
    logic                    w_fifo_drained;
    logic                    w_pop;
    logic [FIFO_W-1:0]       w_fifo_din;
    logic [FIFO_W-1:0]       w_fifo_dout;
    logic [1:0]              w_fifo_count;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    gcbp_rd_tag_t            w_head_tag;
    logic [DATA_W-1:0]       w_bram_words [GCBP_NUM_BRAMS];

    assign w_addr_last = (r_addr == LP_ADDR_LAST);
    assign w_idx_last  = (r_idx == LP_IDX_LAST);

    // A slot freed by this cycle's pop can be claimed by this cycle's read,
    // which keeps one word per cycle flowing with i_ready held high.
    assign w_has_credit   = w_pop || (!w_fifo_full && !((w_fifo_count == 2'd1) && r_inflight));
    assign w_fifo_drained = w_fifo_empty || ((w_fifo_count == 2'd1) && w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_start_acc  = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_start_acc  = 1'b1;
                    w_next_state = READ;
                end
            end
            READ: begin
                o_busy  = 1'b1;
                w_issue = w_has_credit;
                if (w_issue && w_addr_last && w_idx_last) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                o_busy = 1'b1;
                if (!r_inflight && w_fifo_drained) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                o_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign o_bram_array_enb = w_issue ? gcbp_onehot(r_idx) : '0;
    assign o_bram_addrb     = r_addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_addr <= '0;
        end else if (w_start_acc) begin
            r_idx  <= '0;
            r_addr <= '0;
        end else if (w_issue) begin
            if (w_addr_last) begin
                r_addr <= '0;
                if (!w_idx_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Tags and flags travel one cycle behind the read, alongside the BRAM data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
            r_idx_d    <= '0;
            r_cap_tag  <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_idx_d   <= r_idx;
                r_cap_tag <= '{vert:     r_idx[3:2],
                               hori:     r_idx[1:0],
                               sub_last: w_addr_last,
                               last:     w_addr_last && w_idx_last};
            end
        end
    end

    always_comb begin
        for (int k = 0; k < GCBP_NUM_BRAMS; k++) begin
            w_bram_words[k] = i_bram_array_doutb[k*DATA_W +: DATA_W];
        end
    end

    assign w_fifo_din = {w_bram_words[r_idx_d], r_cap_tag};

    gcbp_skid_fifo2 #(
        .WIDTH (FIFO_W)
    ) u_skid_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_inflight),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_valid             = !w_fifo_empty;
    assign w_pop               = o_valid && i_ready;
    assign w_head_tag          = gcbp_rd_tag_t'(w_fifo_dout[TAG_W-1:0]);
    assign o_data              = w_fifo_dout[FIFO_W-1:TAG_W];
    assign o_vert_subimage_cnt = w_head_tag.vert;
    assign o_hori_subimage_cnt = w_head_tag.hori;
    assign o_sub_last          = w_head_tag.sub_last;
    assign o_last              = w_head_tag.last;

`ifdef GCBP_RD_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (o_valid && !i_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
